// File: rtl/seq_div32_16_if.sv
// Operand/result channel of the 32/16 sequential divider.
// Both sides use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both 1. A producer holding valid must keep its payload
// stable until that edge, and the divider never withdraws out_valid or
// changes the result before that edge.
interface seq_div32_16_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] n;
  logic [15:0] d;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic [15:0] rem;
  logic        div_zero;
  logic        overflow;
  logic [1:0]  dbg_state;

  modport master (
    output in_valid, n, d, out_ready,
    input  in_ready, out_valid, q, rem, div_zero, overflow, dbg_state
  );

  modport slave (
    input  in_valid, n, d, out_ready,
    output in_ready, out_valid, q, rem, div_zero, overflow, dbg_state
  );
endinterface

// File: rtl/seq_div32_16.sv
// Restoring unsigned divider, 32-bit dividend by 16-bit divisor, one quotient
// bit per clock. Divide-by-zero and quotient overflow finish in one cycle.
module seq_div32_16 (
  input  logic          clk,
  input  logic          reset,
  seq_div32_16_if.slave dif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [16:0] p, p_nx;
  logic [15:0] sh, sh_nx;
  logic [15:0] dreg, dreg_nx;
  logic [15:0] q_r, q_nx;
  logic [15:0] rem_r, rem_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        dz_r, dz_nx;
  logic        ov_r, ov_nx;

  // Trial remainder is 17 bits so the bit shifted out of P[15] is kept.
  logic [16:0] t;
  logic [16:0] t_sub;
  logic        t_ge;

  assign t     = {p[15:0], sh[15]};
  assign t_ge  = (t >= {1'b0, dreg});
  assign t_sub = t - {1'b0, dreg};

  always_comb begin
    state_nx = state;
    p_nx     = p;
    sh_nx    = sh;
    dreg_nx  = dreg;
    q_nx     = q_r;
    rem_nx   = rem_r;
    cnt_nx   = cnt;
    dz_nx    = dz_r;
    ov_nx    = ov_r;
    case (state)
      IDLE: begin
        if (dif.in_valid) begin
          dreg_nx = dif.d;
          if (dif.d == 16'd0) begin
            state_nx = DONE;
            dz_nx    = 1'b1;
            ov_nx    = 1'b0;
            q_nx     = 16'hFFFF;
            rem_nx   = dif.n[15:0];
          end else if (dif.n[31:16] >= dif.d) begin
            // Quotient would need more than 16 bits.
            state_nx = DONE;
            dz_nx    = 1'b0;
            ov_nx    = 1'b1;
            q_nx     = 16'hFFFF;
            rem_nx   = 16'hFFFF;
          end else begin
            state_nx = BUSY;
            p_nx     = {1'b0, dif.n[31:16]};
            sh_nx    = dif.n[15:0];
            cnt_nx   = 4'd0;
            dz_nx    = 1'b0;
            ov_nx    = 1'b0;
            q_nx     = 16'd0;
          end
        end
      end
      BUSY: begin
        p_nx   = t_ge ? t_sub : t;
        sh_nx  = {sh[14:0], 1'b0};
        q_nx   = {q_r[14:0], t_ge};
        cnt_nx = cnt + 4'd1;
        if (cnt == 4'd15) begin
          state_nx = DONE;
          rem_nx   = t_ge ? t_sub[15:0] : t[15:0];
        end
      end
      DONE: begin
        if (dif.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      p     <= 17'd0;
      sh    <= 16'd0;
      dreg  <= 16'd0;
      q_r   <= 16'd0;
      rem_r <= 16'd0;
      cnt   <= 4'd0;
      dz_r  <= 1'b0;
      ov_r  <= 1'b0;
    end else begin
      state <= state_nx;
      p     <= p_nx;
      sh    <= sh_nx;
      dreg  <= dreg_nx;
      q_r   <= q_nx;
      rem_r <= rem_nx;
      cnt   <= cnt_nx;
      dz_r  <= dz_nx;
      ov_r  <= ov_nx;
    end
  end

  assign dif.in_ready  = (state == IDLE);
  assign dif.out_valid = (state == DONE);
  assign dif.q         = q_r;
  assign dif.rem       = rem_r;
  assign dif.div_zero  = dz_r;
  assign dif.overflow  = ov_r;
  assign dif.dbg_state = state;

endmodule

// File: doc/seq_div32_16.md
Name: seq_div32_16

Overview:
- Multi-cycle unsigned divider: 32-bit dividend by 16-bit divisor, giving a 16-bit quotient and a 16-bit remainder.
- Arithmetic inverse of the 16x16->32 multiplier in the functional-units library: for any product r = a*b (b != 0), seq_div32_16(r, b) returns q = a, rem = 0.
- Restoring division, one quotient bit per clock; valid/ready handshake on both sides.
- Sits beside the multiplier as an ALU functional unit.

Parameters:
- none (widths fixed at 32/16)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  unit can accept operands
- n  input  32  dividend
- d  input  16  divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- q  output  16  quotient
- rem  output  16  remainder
- div_zero  output  1  divisor was zero
- overflow  output  1  quotient does not fit in 16 bits

Behaviour:
- Reset: one clock is synchronous; reset is synchronous and active-high.
- On a clk edge with reset=1:
  - state <= IDLE
  - q, rem <= 0
  - div_zero, overflow <= 0
  - iteration counter <= 0
  - reset has priority over every other event.
- Outputs:
  - in_ready = (state==IDLE), combinational; it is 1 after reset.
  - out_valid = (state==DONE).
- States: IDLE, BUSY, DONE.
- IDLE, accept when in_valid && in_ready at edge E0, latching n and d:
  - d==0 -> DONE; div_zero=1, overflow=0, q=16'hFFFF, rem=n[15:0].
  - else n[31:16] >= d -> DONE; overflow=1, div_zero=0, q=16'hFFFF, rem=16'hFFFF.
  - else -> BUSY; partial remainder P (17 bits) = {1'b0, n[31:16]}, shift register = n[15:0], count=0, both flags=0.
- BUSY iteration (edges E1..E16, one per edge):
  - T = {P[15:0], next dividend bit}, taken MSB first from n[15:0].
  - If T >= {1'b0,d}: P = T - d and the quotient bit is 1; else P = T and the quotient bit is 0.
  - Quotient bits shift into q LSB-first-in, so after 16 steps q[15] is the first bit produced.
  - After E16: state=DONE, rem=P[15:0].
- Invariant: rem < d whenever no flag is set.
- Latency: out_valid rises in the cycle after E16 (17 edges after acceptance).
  - Special cases (div_zero / overflow): out_valid rises in the cycle after E0.
- DONE:
  - q, rem, div_zero and overflow are held stable while out_valid=1 && out_ready=0 (unlimited backpressure).
  - On an edge with out_ready=1: -> IDLE.
  - Outputs keep their last value after leaving DONE; they are only meaningful while out_valid=1.
- No new operand is accepted in BUSY or DONE; in_valid is ignored there, and the producer must hold its operands.
- Same-cycle in_valid and out_ready in DONE: return to IDLE only; the new operand is accepted no earlier than the next cycle. Throughput is at most one division per 18 cycles.
- Operands are latched at acceptance; changes to n or d during BUSY have no effect.
- Reset mid-BUSY or mid-DONE:
  - The operation is aborted and no result is produced.
  - out_valid is 0 in the cycle after reset.
  - in_ready is 1 once reset is deasserted.
- Arithmetic is unsigned only.
- Width rule: the comparison/subtraction is 17 bits wide, so T's MSB is never lost; d is zero-extended.

Test Plan:
- n=32'd100000, d=16'd7, out_ready=1 -> out_valid exactly 17 cycles after acceptance, q=16'd14285 (0x37CD), rem=16'd5, flags 0; in_ready returns to 1 one cycle later.
- n=32'hFFFE0001, d=16'hFFFF -> q=16'hFFFF, rem=0, no flags. Also loop the multiplier products of 200 random a,b pairs (b!=0) -> q=a, rem=0.
- n=32'h00070000, d=16'd7 -> overflow=1, q=16'hFFFF, rem=16'hFFFF, out_valid one cycle after acceptance. Then d=0, n=32'h12345678 -> div_zero=1, q=16'hFFFF, rem=16'h5678.
- Hold out_ready=0 for 10 cycles in DONE, and change n/d and pulse in_valid meanwhile -> q/rem/flags stable, in_ready=0, no second acceptance. Raise out_ready -> IDLE next cycle.
- Assert reset at BUSY iteration 8 -> next cycle out_valid=0, in_ready=1 after deassert. Then a fresh n=32'd1000, d=16'd10 -> q=16'd100, rem=0.
- Random regression, 10k operands with mixed in_valid/out_ready stalls:
  - no flags -> q*d + rem == n and rem < d;
  - flags set exactly when d==0 or n[31:16] >= d.
